// File: rtl/avalon_st_pkg.sv
// Shared definitions for the Avalon-ST ready-latency buffer.
//   ERR_OVERRUN / ERR_FRAMING : bit positions inside the sticky err vector
//   MAX_READY_LATENCY         : largest supported sink-side ready latency
//   empty_w()                 : width of the empty field for a given symbol count
package avalon_st_pkg;

    localparam int unsigned ERR_OVERRUN       = 0;
    localparam int unsigned ERR_FRAMING       = 1;
    localparam int unsigned MAX_READY_LATENCY = 8;

    // At least one bit even for single-symbol beats.
    function automatic int unsigned empty_w(input int unsigned symbols);
        return (symbols > 1) ? $clog2(symbols) : 1;
    endfunction

endpackage

// File: rtl/avalon_st_ready_tracker.sv
// Delays snk_ready by READY_LATENCY cycles to decide whether a beat arriving
// now falls inside the window the sink granted.
//   clk, rst   : clock, asynchronous active-high reset
//   snk_ready  : ready as currently presented to the upstream source
//   window_ok  : ready value from READY_LATENCY cycles ago (RL=0: pass-through)
module avalon_st_ready_tracker #(
    parameter int unsigned READY_LATENCY = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic snk_ready,
    output logic window_ok
);

    generate
        if (READY_LATENCY == 0) begin : g_rl0
            assign window_ok = snk_ready;
        end else begin : g_rln
            logic [READY_LATENCY-1:0] r_hist;

            // r_hist[i] holds snk_ready from i+1 cycles ago.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_hist <= '0;
                end else begin
                    r_hist[0] <= snk_ready;
                    for (int i = 1; i < int'(READY_LATENCY); i++) begin
                        r_hist[i] <= r_hist[i-1];
                    end
                end
            end

            assign window_ok = r_hist[READY_LATENCY-1];
        end
    endgenerate

endmodule

// File: rtl/avalon_st_rl_fifo.sv
// Avalon-ST buffer: ready-latency sink side, RL=0 show-ahead source side.
// Each beat carries sop/eop/empty/channel; overrun and framing violations are
// recorded in a sticky err vector cleared by err_clr.
//   clk, rst                 : clock, asynchronous active-high reset
//   snk_*                    : sink beat, snk_ready honours READY_LATENCY
//   src_*                    : head-of-queue beat, src_valid = not empty
//   err[1:0], err_clr        : sticky {framing, overrun}, synchronous clear
// Optional macro AVST_FILL_LEVEL_EN adds fill_level and almost_full outputs.
module avalon_st_rl_fifo
    import avalon_st_pkg::*;
#(
    parameter  int unsigned DATABITS_PER_SYMBOL = 8,
    parameter  int unsigned SYMBOLS_PER_BEAT    = 4,
    parameter  int unsigned READY_LATENCY       = 2,
    parameter  int unsigned ADDR_W              = 4,
    parameter  int unsigned CHANNEL_W           = 2,
    localparam int unsigned DATA_W              = DATABITS_PER_SYMBOL * SYMBOLS_PER_BEAT,
    localparam int unsigned EMPTY_W             = empty_w(SYMBOLS_PER_BEAT)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DATA_W-1:0]    snk_data,
    input  logic                 snk_valid,
    input  logic                 snk_sop,
    input  logic                 snk_eop,
    input  logic [EMPTY_W-1:0]   snk_empty,
    input  logic [CHANNEL_W-1:0] snk_channel,
    output logic                 snk_ready,
    output logic [DATA_W-1:0]    src_data,
    output logic                 src_valid,
    output logic                 src_sop,
    output logic                 src_eop,
    output logic [EMPTY_W-1:0]   src_empty,
    output logic [CHANNEL_W-1:0] src_channel,
    input  logic                 src_ready,
`ifdef AVST_FILL_LEVEL_EN
    output logic [ADDR_W:0]      fill_level,
    output logic                 almost_full,
`endif
    output logic [1:0]           err,
    input  logic                 err_clr
);

    localparam int unsigned DEPTH     = 2 ** ADDR_W;
    localparam int unsigned WORD_W    = CHANNEL_W + EMPTY_W + 2 + DATA_W;
    // Highest occupancy at which READY_LATENCY further beats still fit.
    localparam int unsigned READY_MAX = DEPTH - READY_LATENCY - 1;

    logic [DEPTH-1:0][WORD_W-1:0] r_mem;
    logic [ADDR_W-1:0]            r_wr_ptr;
    logic [ADDR_W-1:0]            r_rd_ptr;
    logic [ADDR_W:0]              r_used;
    logic                         r_snk_ready;
    logic                         r_in_pkt;
    logic [1:0]                   r_err;

    logic [ADDR_W:0]              w_used_next;
    logic                         w_window_ok;
    logic                         w_full;
    logic                         w_push;
    logic                         w_pop;
    logic                         w_framing;
    logic [1:0]                   w_err_set;
    logic [WORD_W-1:0]            w_head;

    avalon_st_ready_tracker #(
        .READY_LATENCY (READY_LATENCY)
    ) u_ready_tracker (
        .clk       (clk),
        .rst       (rst),
        .snk_ready (r_snk_ready),
        .window_ok (w_window_ok)
    );

    // Accept / drop / pop decisions and next occupancy.
    always_comb begin
        w_full      = (r_used == (ADDR_W+1)'(DEPTH));
        w_push      = snk_valid & w_window_ok & ~w_full;
        w_pop       = (r_used != '0) & src_ready;
        // Legal framing alternates: sop only outside a packet, non-sop only inside.
        w_framing   = w_push & (snk_sop == r_in_pkt);
        w_used_next = r_used + (ADDR_W+1)'(w_push) - (ADDR_W+1)'(w_pop);
        w_err_set                 = '0;
        w_err_set[ERR_OVERRUN]    = snk_valid & ~w_push;
        w_err_set[ERR_FRAMING]    = w_framing;
    end

    // Beat storage, deliberately not reset.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {snk_channel, snk_empty, snk_eop, snk_sop, snk_data};
        end
    end

    // Pointers, occupancy, ready, packet state and sticky errors.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_used      <= '0;
            r_snk_ready <= 1'b0;
            r_in_pkt    <= 1'b0;
            r_err       <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + ADDR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + ADDR_W'(1);
            end
            r_used      <= w_used_next;
            r_snk_ready <= (w_used_next <= (ADDR_W+1)'(READY_MAX));
            if (w_push) begin
                if (snk_eop) begin
                    r_in_pkt <= 1'b0;
                end else if (snk_sop) begin
                    r_in_pkt <= 1'b1;
                end
            end
            // A new error in the clearing cycle keeps its flag set.
            r_err <= (err_clr ? 2'b00 : r_err) | w_err_set;
        end
    end

`ifdef AVST_FILL_LEVEL_EN
    logic r_almost_full;

    // Occupancy at or beyond the point where snk_ready is withdrawn.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_almost_full <= 1'b0;
        end else begin
            r_almost_full <= (w_used_next >= (ADDR_W+1)'(READY_MAX));
        end
    end

    assign fill_level  = r_used;
    assign almost_full = r_almost_full;
`endif

    // Show-ahead source: head entry decoded straight from storage.
    assign w_head      = r_mem[r_rd_ptr];
    assign src_data    = w_head[DATA_W-1:0];
    assign src_sop     = w_head[DATA_W];
    assign src_eop     = w_head[DATA_W+1];
    assign src_empty   = w_head[DATA_W+2 +: EMPTY_W];
    assign src_channel = w_head[DATA_W+2+EMPTY_W +: CHANNEL_W];
    assign src_valid   = (r_used != '0);
    assign snk_ready   = r_snk_ready;
    assign err         = r_err;

endmodule

// File: tb/tb_avalon_st_rl_fifo.sv
module tb_avalon_st_rl_fifo;

    localparam int unsigned DW    = 32;
    localparam int unsigned EW    = 2;
    localparam int unsigned CW    = 2;
    localparam int unsigned AW    = 4;
    localparam int unsigned RL    = 2;
    localparam int          DEPTH = 16;
    localparam int          RMAX  = DEPTH - RL - 1;

    typedef struct packed {
        logic [CW-1:0] ch;
        logic [EW-1:0] emp;
        logic          eop;
        logic          sop;
        logic [DW-1:0] data;
    } beat_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [DW-1:0] snk_data = '0;
    logic          snk_valid = 1'b0;
    logic          snk_sop = 1'b0;
    logic          snk_eop = 1'b0;
    logic [EW-1:0] snk_empty = '0;
    logic [CW-1:0] snk_channel = '0;
    logic          snk_ready;
    logic [DW-1:0] src_data;
    logic          src_valid;
    logic          src_sop;
    logic          src_eop;
    logic [EW-1:0] src_empty;
    logic [CW-1:0] src_channel;
    logic          src_ready = 1'b0;
    logic [1:0]    err;
    logic          err_clr = 1'b0;
`ifdef AVST_FILL_LEVEL_EN
    logic [AW:0]   fill_level;
    logic          almost_full;
`endif

    avalon_st_rl_fifo #(
        .DATABITS_PER_SYMBOL (8),
        .SYMBOLS_PER_BEAT    (4),
        .READY_LATENCY       (RL),
        .ADDR_W              (AW),
        .CHANNEL_W           (CW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .snk_data    (snk_data),
        .snk_valid   (snk_valid),
        .snk_sop     (snk_sop),
        .snk_eop     (snk_eop),
        .snk_empty   (snk_empty),
        .snk_channel (snk_channel),
        .snk_ready   (snk_ready),
        .src_data    (src_data),
        .src_valid   (src_valid),
        .src_sop     (src_sop),
        .src_eop     (src_eop),
        .src_empty   (src_empty),
        .src_channel (src_channel),
        .src_ready   (src_ready),
`ifdef AVST_FILL_LEVEL_EN
        .fill_level  (fill_level),
        .almost_full (almost_full),
`endif
        .err         (err),
        .err_clr     (err_clr)
    );

    always #5 clk = ~clk;

    // Reference model: a queue of accepted beats plus protocol state.
    beat_t      sb[$];
    int         m_used   = 0;
    bit         m_ready  = 1'b0;
    bit         m_in_pkt = 1'b0;
    logic [1:0] m_err    = 2'b00;
    bit         rh[$]    = '{1'b0, 1'b0, 1'b0};
    bit         g_in_pkt = 1'b0;
    int         n_checks = 0;
    int         n_pass   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Ready value granted RL cycles before the current one.
    function automatic bit win();
        return rh[rh.size()-1-RL];
    endfunction

    function automatic beat_t mk(input logic [DW-1:0] d, input bit s, input bit e,
                                 input logic [EW-1:0] emp, input logic [CW-1:0] ch);
        beat_t b;
        b.data = d; b.sop = s; b.eop = e; b.emp = emp; b.ch = ch;
        return b;
    endfunction

    // Random beat; well-formed packets unless wild is set.
    task automatic gen_beat(input bit wild, output beat_t b);
        bit s, e;
        if (wild) begin
            s = 1'($urandom); e = 1'($urandom);
        end else begin
            s = !g_in_pkt; e = ($urandom_range(0, 2) == 0);
            g_in_pkt = !e;
        end
        b = mk($urandom, s, e, EW'($urandom), CW'($urandom));
    endtask

    // One clock cycle of stimulus plus the model's view of it.
    task automatic cycle(input bit r, input bit v, input beat_t b, input bit sr, input bit clr);
        bit legal = 1'b0;
        bit pop   = 1'b0;
        logic [1:0] e = 2'b00;
        rst = r; snk_valid = v; src_ready = sr; err_clr = clr;
        snk_data = b.data; snk_sop = b.sop; snk_eop = b.eop; snk_empty = b.emp; snk_channel = b.ch;
        if (r) begin
            sb.delete(); m_used = 0; m_ready = 0; m_in_pkt = 0; m_err = 2'b00;
            rh = '{1'b0, 1'b0, 1'b0};
        end else begin
            legal = v && win() && (m_used < DEPTH);
            pop   = (m_used > 0) && sr;
            e[0]  = v && !legal;
            if (legal) begin
                e[1] = (b.sop && m_in_pkt) || (!b.sop && !m_in_pkt);
                if (b.eop) m_in_pkt = 0;
                else if (b.sop) m_in_pkt = 1;
                sb.push_back(b);
            end
        end
        @(posedge clk);
        #1;
        if (!r) begin
            m_used  = m_used + int'(legal) - int'(pop);
            m_err   = (clr ? 2'b00 : m_err) | e;
            m_ready = (m_used <= RMAX);
        end
        rh.push_back(m_ready);
        if (rh.size() > 16) void'(rh.pop_front());
    endtask

    // Monitor: control outputs every cycle, head beat whenever valid, pop on handshake.
    initial begin
        beat_t exp_b;
        forever begin
            @(negedge clk);
            check("snk_ready", 64'(snk_ready), 64'(m_ready));
            check("src_valid", 64'(src_valid), 64'(m_used != 0));
            check("err", 64'(err), 64'(m_err));
`ifdef AVST_FILL_LEVEL_EN
            check("fill_level", 64'(fill_level), 64'(m_used));
            check("almost_full", 64'(almost_full), 64'(m_used >= RMAX));
`endif
            if (src_valid) begin
                if (sb.size() == 0) begin
                    check("head_present", 64'(1), 64'(0));
                end else begin
                    exp_b = sb[0];
                    check("head_beat", 64'({src_channel, src_empty, src_eop, src_sop, src_data}),
                          64'(exp_b));
                    if (src_ready) void'(sb.pop_front());
                end
            end
        end
    end

    initial begin
        beat_t b;
        int    seq;
        bit    v;
        int    sr_bias;

        // Reset and first ready.
        repeat (3) cycle(1, 0, '0, 0, 0);
        repeat (3) cycle(0, 0, '0, 0, 0);

        // Fill beats 0..19 with the source stalled, then drain in order.
        seq = 0;
        for (int i = 0; i < 40; i++) begin
            v = win() && (seq < 20);
            cycle(0, v, mk(DW'(seq), 1, 1, '0, '0), 0, 0);
            if (v) seq++;
        end
        for (int i = 0; i < 40; i++) begin
            v = win() && (seq < 20);
            cycle(0, v, mk(DW'(seq), 1, 1, '0, '0), 1, 0);
            if (v) seq++;
        end

        // Overrun: keep driving regardless of the window, then clear.
        for (int i = 0; i < 25; i++) cycle(0, 1, mk($urandom, 1, 1, '0, '1), 0, 0);
        cycle(0, 0, '0, 0, 1);
        repeat (25) cycle(0, 0, '0, 1, 0);

        // Packet sideband, then a sop-sop framing error, then close the packet.
        cycle(0, 1, mk(32'hA0, 1, 0, 0, 2), 0, 0);
        cycle(0, 1, mk(32'hA1, 0, 0, 1, 2), 0, 0);
        cycle(0, 1, mk(32'hA2, 0, 0, 2, 2), 1, 0);
        cycle(0, 1, mk(32'hA3, 0, 1, 3, 2), 1, 0);
        cycle(0, 1, mk(32'hB0, 1, 0, 0, 1), 1, 0);
        cycle(0, 1, mk(32'hB1, 1, 0, 0, 1), 1, 0);
        cycle(0, 1, mk(32'hB2, 0, 1, 1, 1), 1, 1);
        repeat (8) cycle(0, 0, '0, 1, 0);
        cycle(0, 0, '0, 0, 1);

        // Steady push+pop at occupancy 5 across the pointer wrap.
        for (int i = 0; i < 5; i++) cycle(0, 1, mk(DW'(100 + i), 1, 1, '0, '0), 0, 0);
        for (int i = 0; i < 10; i++) cycle(0, 1, mk(DW'(200 + i), 1, 1, '0, '0), 1, 0);
        repeat (8) cycle(0, 0, '0, 1, 0);

        // Randomized traffic, occasional violations, clears and resets.
        g_in_pkt = 0;
        sr_bias  = 50;
        for (int i = 0; i < 3000; i++) begin
            if (i % 200 == 0) sr_bias = $urandom_range(10, 95);
            if ($urandom_range(0, 399) == 0) begin
                g_in_pkt = 0;
                cycle(1, 0, '0, 0, 0);
            end else begin
                gen_beat($urandom_range(0, 15) == 0, b);
                if ($urandom_range(0, 19) == 0) v = 1'($urandom);
                else v = win() && ($urandom_range(0, 99) < 70);
                if (!v) g_in_pkt = m_in_pkt;
                cycle(0, v, b, ($urandom_range(0, 99) < sr_bias), ($urandom_range(0, 29) == 0));
            end
        end

        // Reset mid-packet: first beat afterwards must carry sop.
        repeat (20) cycle(0, 0, '0, 1, 1);
        cycle(0, 1, mk(32'hC0, 1, 0, 0, 0), 0, 0);
        cycle(0, 1, mk(32'hC1, 0, 0, 0, 0), 0, 0);
        cycle(1, 0, '0, 0, 0);
        repeat (3) cycle(0, 0, '0, 0, 0);
        cycle(0, 1, mk(32'hD0, 0, 1, 0, 0), 1, 0);
        cycle(0, 1, mk(32'hD1, 1, 1, 0, 0), 1, 0);
        repeat (4) cycle(0, 0, '0, 1, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
